// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR generator and checker blocks.
package lfsr_pkg;

  localparam int LFSR_W = 8;

  // Checker synchronisation state.
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lfsr_state_t;

  // LFSR next-state function, shared with the generator so both sides agree.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
  endfunction

endpackage

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the LFSR byte stream: hunts for a run of
// consecutive correct successors, then free-runs its own prediction and
// counts mismatches, dropping lock after a run of misses.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_MATCHES = 4,
  parameter int LOSS_MISSES  = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_cnt,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  output logic              locked,
  output logic              sync_lost,
  output logic              err_pulse,
  output logic              zero_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  byte_cnt
);

  localparam int HUNT_W = $clog2(LOCK_MATCHES + 1);
  localparam int MISS_W = $clog2(LOSS_MISSES + 1);

  lfsr_state_t       state, state_n;
  logic              seeded, seeded_n;
  logic [HUNT_W-1:0] hunt_cnt, hunt_n;
  logic [MISS_W-1:0] miss_cnt, miss_n;
  logic [LFSR_W-1:0] ref_byte, ref_n;
  logic [LFSR_W-1:0] exp_byte, exp_n;
  logic              sync_lost_n;
  logic              err_n;
  logic              zero_n;
  logic              byte_inc;

  // State, prediction and pulse registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= HUNT;
      seeded    <= 1'b0;
      hunt_cnt  <= '0;
      miss_cnt  <= '0;
      ref_byte  <= '0;
      exp_byte  <= '0;
      locked    <= 1'b0;
      sync_lost <= 1'b0;
      err_pulse <= 1'b0;
      zero_err  <= 1'b0;
    end else begin
      state     <= state_n;
      seeded    <= seeded_n;
      hunt_cnt  <= hunt_n;
      miss_cnt  <= miss_n;
      ref_byte  <= ref_n;
      exp_byte  <= exp_n;
      locked    <= (state_n == LOCKED);
      sync_lost <= sync_lost_n;
      err_pulse <= err_n;
      zero_err  <= zero_n;
    end
  end

  // Next-state logic: seed and chain in HUNT, free-running prediction in LOCKED.
  always_comb begin
    state_n     = state;
    seeded_n    = seeded;
    hunt_n      = hunt_cnt;
    miss_n      = miss_cnt;
    ref_n       = ref_byte;
    exp_n       = exp_byte;
    sync_lost_n = 1'b0;
    err_n       = 1'b0;
    zero_n      = 1'b0;
    byte_inc    = 1'b0;
    if (in_valid) begin
      zero_n = (in_data == '0);
      case (state)
        HUNT: begin
          if (!seeded) begin
            if (in_data != '0) begin
              ref_n    = in_data;
              seeded_n = 1'b1;
              hunt_n   = '0;
            end
          end else if (in_data == lfsr_next(ref_byte)) begin
            ref_n = in_data;
            if (hunt_cnt == HUNT_W'(LOCK_MATCHES - 1)) begin
              state_n = LOCKED;
              hunt_n  = '0;
              miss_n  = '0;
              exp_n   = lfsr_next(in_data);
            end else begin
              hunt_n = hunt_cnt + HUNT_W'(1);
            end
          end else begin
            hunt_n = '0;
            if (in_data != '0) begin
              ref_n = in_data;
            end else begin
              seeded_n = 1'b0;
            end
          end
        end
        LOCKED: begin
          byte_inc = 1'b1;
          exp_n    = lfsr_next(exp_byte);
          if (in_data != exp_byte) begin
            err_n = 1'b1;
            if (miss_cnt == MISS_W'(LOSS_MISSES - 1)) begin
              state_n     = HUNT;
              seeded_n    = 1'b0;
              hunt_n      = '0;
              miss_n      = '0;
              sync_lost_n = 1'b1;
            end else begin
              miss_n = miss_cnt + MISS_W'(1);
            end
          end else begin
            miss_n = '0;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // Saturating error and byte counters; a clear drops any coincident increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt  <= '0;
      byte_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      if (err_n && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      if (byte_inc && (byte_cnt != '1)) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Self-checking bench for lfsr_seq_checker: directed byte streams, a
// chain-length reference model compared every cycle, and literal checkpoints.
module tb_lfsr_seq_checker;

  localparam int LM  = 4;
  localparam int LS  = 3;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_cnt;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          locked;
  logic          sync_lost;
  logic          err_pulse;
  logic          zero_err;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] byte_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfsr_seq_checker #(
    .LOCK_MATCHES(LM),
    .LOSS_MISSES (LS),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_cnt  (clr_cnt),
    .in_valid (in_valid),
    .in_data  (in_data),
    .locked   (locked),
    .sync_lost(sync_lost),
    .err_pulse(err_pulse),
    .zero_err (zero_err),
    .err_cnt  (err_cnt),
    .byte_cnt (byte_cnt)
  );

  // Successor byte: feedback is the parity of taps 4,3,2,0 (mask 0x1D), shifted in at the top.
  function automatic logic [7:0] bnext(input logic [7:0] s);
    logic fb;
    fb = ^(s & 8'h1D);
    return {fb, s[7:1]};
  endfunction

  // One comparison: counts it, reports a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endtask

  // Model: HUNT tracks the length of the current chain of successive bytes,
  // LOCKED tracks the free-running prediction and the run of misses.
  bit         ready = 0;
  bit         m_locked, m_sync, m_err, m_zero;
  int         chain, m_miss, m_errc, m_bytec;
  logic [7:0] last, pred;

  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      ready = 1; m_locked = 0; m_sync = 0; m_err = 0; m_zero = 0;
      chain = 0; m_miss = 0; m_errc = 0; m_bytec = 0; last = 0; pred = 0;
    end else begin
      m_sync = 0; m_err = 0; m_zero = 0;
      if (in_valid) begin
        m_zero = (in_data == 8'h00);
        if (!m_locked) begin
          if (in_data == 8'h00) begin
            chain = 0;
          end else if (chain > 0 && in_data == bnext(last)) begin
            chain++;
            last = in_data;
            if (chain == LM + 1) begin
              m_locked = 1; m_miss = 0; pred = bnext(in_data);
            end
          end else begin
            chain = 1;
            last  = in_data;
          end
        end else begin
          if (m_bytec < SAT) m_bytec++;
          if (in_data != pred) begin
            m_err = 1;
            if (m_errc < SAT) m_errc++;
            m_miss++;
            if (m_miss == LS) begin
              m_locked = 0; m_sync = 1; chain = 0;
            end
          end else begin
            m_miss = 0;
          end
          pred = bnext(pred);
        end
      end
      if (clr_cnt) begin
        m_errc = 0; m_bytec = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (ready) begin
      checkOutput("cyc_locked",    locked,    m_locked);
      checkOutput("cyc_sync_lost", sync_lost, m_sync);
      checkOutput("cyc_err_pulse", err_pulse, m_err);
      checkOutput("cyc_zero_err",  zero_err,  m_zero);
      checkOutput("cyc_err_cnt",   err_cnt,   m_errc);
      checkOutput("cyc_byte_cnt",  byte_cnt,  m_bytec);
    end
  end

  // Drive one cycle of inputs, then return just after the edge that sampled them.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clr_cnt  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_locked"},    locked,    0);
    checkOutput({tag, "_sync_lost"}, sync_lost, 0);
    checkOutput({tag, "_err_pulse"}, err_pulse, 0);
    checkOutput({tag, "_zero_err"},  zero_err,  0);
    checkOutput({tag, "_err_cnt"},   err_cnt,   0);
    checkOutput({tag, "_byte_cnt"},  byte_cnt,  0);
  endtask

  task automatic relock(input string tag);
    feed(8'hFF); feed(8'h7F); feed(8'h3F); feed(8'h1F);
    checkOutput({tag, "_prelock"}, locked, 0);
    feed(8'h0F);
    checkOutput({tag, "_lock"}, locked, 1);
  endtask

  logic [7:0] nxt;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; clr_cnt = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    checkAllZero("reset");

    // 1: initial lock
    relock("t1");
    checkOutput("t1_err_cnt", err_cnt, 0);

    // 2: single corrupted byte while locked
    feed(8'h87);
    checkOutput("t2_87_err", err_pulse, 0);
    feed(8'h42);
    checkOutput("t2_42_err", err_pulse, 1);
    checkOutput("t2_42_cnt", err_cnt, 1);
    feed(8'hA1);
    checkOutput("t2_A1_err", err_pulse, 0);
    checkOutput("t2_A1_locked", locked, 1);
    checkOutput("t2_byte_cnt", byte_cnt, 3);

    // 3: three misses drop lock, then re-lock
    feed(8'h55); feed(8'h55);
    checkOutput("t3_mid_sync", sync_lost, 0);
    feed(8'h55);
    checkOutput("t3_sync_lost", sync_lost, 1);
    checkOutput("t3_err_pulse", err_pulse, 1);
    checkOutput("t3_locked", locked, 0);
    checkOutput("t3_err_cnt", err_cnt, 4);
    checkOutput("t3_byte_cnt", byte_cnt, 6);
    relock("t3r");

    // 4: lose lock, zero bytes in HUNT, then lock normally
    feed(8'h11); feed(8'h11); feed(8'h11);
    checkOutput("t4_unlocked", locked, 0);
    for (int i = 0; i < 3; i++) begin
      feed(8'h00);
      checkOutput("t4_zero_err", zero_err, 1);
      checkOutput("t4_zero_locked", locked, 0);
    end
    relock("t4r");
    checkOutput("t4_err_cnt", err_cnt, 7);

    // 5: clear coincident with a mismatch (expected A1, send 00)
    feed(8'h87); feed(8'h43);
    applyStimulus(1'b1, 8'h00, 1'b1);
    checkOutput("t5_err_pulse", err_pulse, 1);
    checkOutput("t5_zero_err", zero_err, 1);
    checkOutput("t5_err_cnt", err_cnt, 0);
    checkOutput("t5_byte_cnt", byte_cnt, 0);
    checkOutput("t5_locked", locked, 1);
    feed(8'hD0);
    checkOutput("t5_D0_byte_cnt", byte_cnt, 1);
    nxt = 8'hE8;

    // 6: valid gaps, saturation, then mid-stream reset
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      feed(nxt);
      nxt = bnext(nxt);
    end
    checkOutput("t6_gap_err_cnt", err_cnt, 0);
    checkOutput("t6_gap_byte_cnt", byte_cnt, 7);
    for (int i = 0; i < 10; i++) begin
      feed(nxt);
      nxt = bnext(nxt);
    end
    checkOutput("t6_byte_sat", byte_cnt, SAT);
    for (int i = 0; i < 20; i++) begin
      feed(nxt ^ 8'h01);
      nxt = bnext(nxt);
      feed(nxt);
      nxt = bnext(nxt);
    end
    checkOutput("t6_err_sat", err_cnt, SAT);
    checkOutput("t6_sat_locked", locked, 1);
    rst = 1'b0;
    feed(nxt);
    nxt = bnext(nxt);
    rst = 1'b1;
    checkAllZero("t6_rst");
    feed(nxt);
    checkOutput("t6_hunt_locked", locked, 0);
    checkOutput("t6_hunt_byte_cnt", byte_cnt, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
